// File: rtl/sha3_scan_job_loader.sv
// sha3_scan_job_loader
// Host-side driver for the SHA3 scanner control block. A job arrives as 26
// 32-bit words: 24 block-template words, then the threshold low word, then
// the threshold high word. The loader then requests a scan and waits for it
// to complete. It captures the found flag, the nonce and the 25 hash lanes,
// and streams them back to the host as a 52-word packet.
//
// Optional build macro SHA3_SCAN_LOADER_CYCLE_COUNT_EN adds a saturating
// busy-cycle counter. The counter is appended to the packet as word 52.
//
// Handshake rule for both streams: a word moves on a rising clock edge
// where valid & ready are both high. Once out_valid is raised, out_data and
// out_last hold steady until that edge happens.
//
// dbg_state packs {st_dispatching, seen_busy, fsm_state[1:0]} for monitors.
module sha3_scan_job_loader #(
  parameter int TEMPLATE_WORDS = 24,
  parameter int HASH_LANES     = 25
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic [TEMPLATE_WORDS*32-1:0] req_block_template,
  output logic [63:0]                  req_threshold,
  output logic                         req_start,
  input  logic                         st_ready,
  input  logic                         st_dispatching,
  input  logic                         res_found,
  input  logic [31:0]                  res_nonce,
  input  logic [HASH_LANES*64-1:0]     res_hash,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic                         out_last,
  output logic [3:0]                   dbg_state
);

  localparam int HASH_WORDS = 2 * HASH_LANES;
  // Index of the last job word; it carries the threshold high half.
  localparam logic [5:0] LOAD_LAST = 6'(TEMPLATE_WORDS + 1);
  localparam logic [5:0] THR_LO    = 6'(TEMPLATE_WORDS);
`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
  localparam logic [5:0] PKT_LAST  = 6'(2 + HASH_WORDS);
`else
  localparam logic [5:0] PKT_LAST  = 6'(1 + HASH_WORDS);
`endif

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_START  = 2'd1,
    S_BUSY   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [5:0]                    word_cnt_q, word_cnt_d;
  logic                          seen_busy_q, seen_busy_d;
  logic                          load_we;
  logic                          capture_en;

  logic [TEMPLATE_WORDS*32-1:0]  tmpl_q;
  logic [63:0]                   thr_q;
  logic                          found_q;
  logic [31:0]                   nonce_q;
  logic [HASH_LANES*64-1:0]      hash_q;

`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
  logic [31:0]                   cyc_q;
  logic [31:0]                   cyc_cap_q;
  logic [31:0]                   cyc_inc;
`endif

  // State register, word counter and busy-seen flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      word_cnt_q  <= 6'd0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  // Next-state logic. The word counter is shared between job loading and
  // result reporting. It is cleared whenever the FSM leaves either phase.
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    seen_busy_d = seen_busy_q;
    load_we     = 1'b0;
    capture_en  = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          if (word_cnt_q == LOAD_LAST) begin
            word_cnt_d = 6'd0;
            state_d    = S_START;
          end else begin
            word_cnt_d = word_cnt_q + 6'd1;
          end
        end
      end
      S_START: begin
        // The scanner may still be flushing an earlier job, for example one
        // orphaned by a reset. Hold the start request until it reports idle.
        if (st_ready) begin
          state_d     = S_BUSY;
          seen_busy_d = 1'b0;
        end
      end
      S_BUSY: begin
        // st_ready can stay high for a few cycles after the start strobe.
        // Completion counts only once the scanner has been seen busy.
        if (!st_ready) begin
          seen_busy_d = 1'b1;
        end
        if (seen_busy_q && st_ready) begin
          capture_en  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: begin
        if (out_ready) begin
          if (word_cnt_q == PKT_LAST) begin
            word_cnt_d = 6'd0;
            state_d    = S_LOAD;
          end else begin
            word_cnt_d = word_cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d    = S_LOAD;
        word_cnt_d = 6'd0;
      end
    endcase
  end

  // Job registers. They change only on S_LOAD writes, so the threshold stays
  // stable while the scanner compares against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmpl_q <= '0;
      thr_q  <= 64'd0;
    end else if (load_we) begin
      for (int k = 0; k < TEMPLATE_WORDS; k++) begin
        if (word_cnt_q == 6'(k)) begin
          tmpl_q[k*32 +: 32] <= in_data;
        end
      end
      if (word_cnt_q == THR_LO) begin
        thr_q[31:0] <= in_data;
      end
      if (word_cnt_q == LOAD_LAST) begin
        thr_q[63:32] <= in_data;
      end
    end
  end

  // Result capture. The scanner buses are sampled once, at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      found_q <= 1'b0;
      nonce_q <= 32'd0;
      hash_q  <= '0;
    end else if (capture_en) begin
      found_q <= res_found;
      nonce_q <= res_nonce;
      hash_q  <= res_hash;
    end
  end

`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
  assign cyc_inc = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  // Busy-cycle counter. It clears on the start strobe and counts every
  // S_BUSY cycle, including the capture cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= 32'd0;
      cyc_cap_q <= 32'd0;
    end else begin
      if (req_start) begin
        cyc_q <= 32'd0;
      end else if (state_q == S_BUSY) begin
        cyc_q <= cyc_inc;
      end
      if (capture_en) begin
        cyc_cap_q <= cyc_inc;
      end
    end
  end
`endif

  // Output decode. Output words are selected from registers by the word
  // counter, so they hold naturally while the host stalls.
  always_comb begin
    in_ready  = (state_q == S_LOAD);
    req_start = (state_q == S_START) && st_ready;
    out_valid = (state_q == S_REPORT);
    out_last  = (state_q == S_REPORT) && (word_cnt_q == PKT_LAST);
    out_data  = 32'd0;
    if (state_q == S_REPORT) begin
      if (word_cnt_q == 6'd0) begin
        out_data = {31'd0, found_q};
      end else if (word_cnt_q == 6'd1) begin
        out_data = nonce_q;
`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
      end else if (word_cnt_q == PKT_LAST) begin
        out_data = cyc_cap_q;
`endif
      end else begin
        // Hash words alternate low/high halves of each lane. Packet word w+2
        // is therefore bit slice w of the flat lane vector.
        for (int w = 0; w < HASH_WORDS; w++) begin
          if (word_cnt_q == 6'(w + 2)) begin
            out_data = hash_q[w*32 +: 32];
          end
        end
      end
    end
  end

  assign req_block_template = tmpl_q;
  assign req_threshold      = thr_q;
  assign dbg_state          = {st_dispatching, seen_busy_q, state_q};

endmodule

// File: tb/tb_sha3_scan_job_loader.sv
// Testbench for sha3_scan_job_loader. The bench loads jobs and plays the
// scanner. It holds an expected packet queue built from the job results and
// checks every streamed word against it under random host backpressure.
module tb_sha3_scan_job_loader;

`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
  localparam int PKT_WORDS = 53;
`else
  localparam int PKT_WORDS = 52;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic [767:0]  req_block_template;
  logic [63:0]   req_threshold;
  logic          req_start;
  logic          st_ready;
  logic          st_dispatching;
  logic          res_found;
  logic [31:0]   res_nonce;
  logic [1599:0] res_hash;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic [3:0]    dbg_state;

  always #5 clk = ~clk;

  sha3_scan_job_loader dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .req_block_template (req_block_template),
    .req_threshold      (req_threshold),
    .req_start          (req_start),
    .st_ready           (st_ready),
    .st_dispatching     (st_dispatching),
    .res_found          (res_found),
    .res_nonce          (res_nonce),
    .res_hash           (res_hash),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_last           (out_last),
    .dbg_state          (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           errors = 0;
  int           checks = 0;
  int           start_pulses = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  got_pkt [64];
  int           got_n = 0;
  logic [63:0]  lanes [25];
  bit           stall_prev = 0;
  logic [31:0]  prev_data = 32'd0;
  logic         prev_last = 1'b0;
  int           last_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: the packet is found, nonce, each lane low then high, and
  // optionally the busy-cycle count.
  task automatic push_packet(input logic f, input logic [31:0] nonce, input int cyc);
    exp_q.push_back({31'd0, f});
    exp_q.push_back(nonce);
    for (int i = 0; i < 25; i++) begin
      exp_q.push_back(lanes[i][31:0]);
      exp_q.push_back(lanes[i][63:32]);
    end
    last_cyc = cyc;
`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
    exp_q.push_back(32'(cyc));
`endif
  endtask

  // Count start strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (req_start) start_pulses++;
  end

  // Compare process: check the output stream against the model, then drive
  // random backpressure for the next edge.
  always @(negedge clk) begin
    bit rdy;
    rdy = bit'($urandom_range(0, 1));
    if (out_valid) begin
      if (stall_prev) begin
        chk("stall_hold_data", 64'(out_data), 64'(prev_data));
        chk("stall_hold_last", 64'(out_last), 64'(prev_last));
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        chk("pkt_data", 64'(out_data), 64'(exp_q[0]));
        chk("pkt_last", 64'(out_last), 64'(exp_q.size() == 1));
      end
      if (rdy) begin
        if (got_n < 64) got_pkt[got_n] = out_data;
        got_n++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        stall_prev = 0;
      end else begin
        stall_prev = 1;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end else begin
      stall_prev = 0;
    end
    out_ready = rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] w);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      chk("no_start_during_load", 64'(req_start), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("in_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_job(input logic [31:0] base, input logic [63:0] thr);
    logic [31:0] w;
    for (int k = 0; k < 26; k++) begin
      if (k < 24)       w = base + 32'(k);
      else if (k == 24) w = thr[31:0];
      else              w = thr[63:32];
      send_word(w);
    end
  endtask

  task automatic wait_start(output int lat);
    bit seen;
    seen = 0;
    lat = 0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      seen = req_start;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("start_seen", 64'(seen), 64'd1);
  endtask

  // Scanner model: idle for hi_n busy cycles, busy for lo_n cycles, then
  // done with results. The results are scrambled afterwards so the bench
  // catches any late sampling.
  task automatic busy_phase(input int hi_n, input int lo_n, input logic f, input logic [31:0] nonce);
    repeat (hi_n) begin @(posedge clk); #1; end
    st_ready = 1'b0;
    repeat (lo_n) begin @(posedge clk); #1; end
    res_found = f;
    res_nonce = nonce;
    for (int i = 0; i < 25; i++) res_hash[i*64 +: 64] = lanes[i];
    st_ready = 1'b1;
    push_packet(f, nonce, hi_n + lo_n + 1);
    @(posedge clk);
    #1;
    res_found = ~f;
    res_nonce = ~nonce;
    for (int i = 0; i < 50; i++) res_hash[i*32 +: 32] = $urandom();
  endtask

  task automatic wait_packet();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("packet_timeout_left", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pkt_word_count", 64'(got_n), 64'(PKT_WORDS));
    chk("back_to_load", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int p0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 32'd0;
    st_ready = 1'b1;
    st_dispatching = 1'b0;
    res_found = 1'b0;
    res_nonce = 32'd0;
    res_hash = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 25; i++) lanes[i] = 64'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_req_start", 64'(req_start), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_threshold", req_threshold, 64'd0);
    chk("rst_template_or", 64'(|req_block_template), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Job 1: scanner ready at load end; 100 busy cycles; found.
    got_n = 0;
    p0 = start_pulses;
    send_job(32'h1000, 64'h0000_0000_FFFF_FFFF);
    chk("t1_template5", 64'(req_block_template[5*32 +: 32]), 64'h1005);
    chk("t1_template23", 64'(req_block_template[23*32 +: 32]), 64'h1017);
    chk("t1_threshold", req_threshold, 64'h0000_0000_FFFF_FFFF);
    wait_start(lat);
    chk("t1_start_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 25; i++) lanes[i] = {32'hA0 + 32'(i), 32'hB0 + 32'(i)};
    busy_phase(0, 100, 1'b1, 32'h2A);
    chk("t1_threshold_hold", req_threshold, 64'h0000_0000_FFFF_FFFF);
    wait_packet();
    chk("t1_start_pulses", 64'(start_pulses - p0), 64'd1);
    chk("t1_w0", 64'(got_pkt[0]), 64'h1);
    chk("t1_w1", 64'(got_pkt[1]), 64'h2A);
    chk("t1_w2", 64'(got_pkt[2]), 64'hB0);
    chk("t1_w3", 64'(got_pkt[3]), 64'hA0);
    chk("t1_w50", 64'(got_pkt[50]), 64'hC8);
    chk("t1_w51", 64'(got_pkt[51]), 64'hB8);
`ifdef SHA3_SCAN_LOADER_CYCLE_COUNT_EN
    chk("t1_cycles", 64'(got_pkt[52]), 64'd101);
`endif

    // Job 2: scanner still busy at load end; idle for a few busy cycles
    // before it drops st_ready; not found.
    got_n = 0;
    p0 = start_pulses;
    st_ready = 1'b0;
    send_job(32'h2000, 64'h0000_0001_0000_0002);
    repeat (5) begin
      @(negedge clk);
      chk("t2_start_held", 64'(req_start), 64'd0);
    end
    @(posedge clk);
    #1;
    st_ready = 1'b1;
    wait_start(lat);
    chk("t2_start_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 25; i++) lanes[i] = 64'd0;
    busy_phase(3, 10, 1'b0, 32'h77);
    wait_packet();
    chk("t2_start_pulses", 64'(start_pulses - p0), 64'd1);
    chk("t2_w0", 64'(got_pkt[0]), 64'h0);
    chk("t2_w1", 64'(got_pkt[1]), 64'h77);
    chk("t2_w2", 64'(got_pkt[2]), 64'h0);
    chk("t2_threshold", req_threshold, 64'h0000_0001_0000_0002);

    // Job 3: reset in the middle of a load, then a fresh job.
    got_n = 0;
    for (int k = 0; k < 13; k++) send_word(32'h5000 + 32'(k));
    in_valid = 1'b1;
    in_data = 32'h0000_0BAD;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_rst_template0", 64'(req_block_template[31:0]), 64'd0);
    chk("t3_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t3_rst_req_start", 64'(req_start), 64'd0);
    @(posedge clk);
    #1;
    p0 = start_pulses;
    send_job(32'h3000, 64'h1234_5678_9ABC_DEF0);
    for (int k = 0; k < 24; k++)
      chk("t3_template", 64'(req_block_template[k*32 +: 32]), 64'(32'h3000 + 32'(k)));
    chk("t3_threshold", req_threshold, 64'h1234_5678_9ABC_DEF0);
    wait_start(lat);
    chk("t3_start_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom(), $urandom()};
    busy_phase(1, 5, 1'b1, 32'hDEAD_BEEF);
    wait_packet();
    chk("t3_start_pulses", 64'(start_pulses - p0), 64'd1);
    chk("t3_w1", 64'(got_pkt[1]), 64'hDEAD_BEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Run-time bound.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha3_scan_job_loader.md
Name: sha3_scan_job_loader

Overview:
- Host-side driver of the SHA3 scanner control block.
- Accepts a scan job as a 32-bit word stream, presents it as a scan request (template, threshold, start), and waits for the scan to complete.
- Captures the found flag, nonce and 25-lane hash, then serialises the result back out as a 32-bit word stream.
- Sits between the host link (UART/AXI-stream bridge) and the scanner's request, result and status buses.

Parameters:
- TEMPLATE_WORDS, 24, number of 32-bit block template words per job. Fixed by the scanner: rows a, b and c[0..1].
- HASH_LANES, 25, number of 64-bit hash lanes reported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  job word valid
- in_ready  out  1  job word accepted when in_valid & in_ready
- in_data  in  32  job word
- req_block_template  out  24x32  request template words, index 0 first
- req_threshold  out  64  request difficulty threshold
- req_start  out  1  request start strobe
- st_ready  in  1  scanner status ready (idle)
- st_dispatching  in  1  scanner status dispatching (monitor only)
- res_found  in  1  scanner result found
- res_nonce  in  32  scanner result nonce offset
- res_hash  in  25x64  scanner result hash lanes
- out_valid  out  1  result word valid
- out_ready  in  1  result word consumed when out_valid & out_ready
- out_data  out  32  result word
- out_last  out  1  final word of the result packet

Behaviour:
- States: S_LOAD, S_START, S_BUSY, S_REPORT. Reset state: S_LOAD.
- Reset values: in_ready=1, req_start=0, out_valid=0, out_last=0, out_data=0, req_block_template=0, req_threshold=0. Word and seen-busy counters are 0.
- S_LOAD:
  - in_ready=1.
  - Accepted word k (0..23) is written to req_block_template[k].
  - Word 24 is written to req_threshold[31:0]; word 25 to req_threshold[63:32].
  - Acceptance of word 25 moves to S_START on the same edge.
  - in_valid low stalls with no effect. No timeout.
- S_START:
  - in_ready=0.
  - req_start = (state==S_START) & st_ready, combinational.
  - On the first edge where st_ready=1, move to S_BUSY. If st_ready=0 (scanner still flushing a previous job), wait.
- S_BUSY:
  - A seen_busy flag is set on any cycle with st_ready=0.
  - When seen_busy & st_ready, capture res_found, res_nonce and res_hash into local registers, clear seen_busy, and move to S_REPORT.
- Stability: req_block_template and req_threshold hold from load until the next S_LOAD write. The scanner compares the threshold live during evaluation, so it must not change mid-scan.
- S_REPORT packet, 52 words, in order:
  - Word 0: {31'b0, found}.
  - Word 1: nonce.
  - Words 2+2i and 3+2i: hash lane i bits [31:0] then [63:32], for i=0..24.
  - out_last=1 on word 51 only.
  - out_data and out_last hold while out_valid & ~out_ready.
  - After the word-51 handshake: out_valid=0, word counter cleared, return to S_LOAD on the same edge.
  - When not found, hash lanes are reported as the captured values (zero from the scanner).
- Word counter: 6-bit. It wraps only via explicit clear on state exit and never counts past 51.
- Reset mid-operation: immediately returns to S_LOAD.
  - Partial job and partial packet are discarded.
  - req_start drops in the same cycle reset is sampled.
  - The scanner itself is not reset. An in-flight scan completes unobserved, and the next job's S_START waits for st_ready.
- Simultaneous events: in S_LOAD, in_valid is ignored while rst=1. out_ready is ignored outside S_REPORT.

Optional Feature:
- Macro SHA3_SCAN_LOADER_CYCLE_COUNT_EN.
- When defined:
  - A 32-bit saturating counter clears on the req_start cycle.
  - It increments every S_BUSY cycle and saturates at 32'hFFFFFFFF.
  - It is captured together with the results.
  - The packet grows to 53 words: the count is word 52, and out_last moves to word 52.
- When undefined: no counter exists, and the packet is exactly 52 words.

Test Plan:
- Send 26 words (template words 0x1000+k, threshold 0x00000000_FFFFFFFF) with st_ready=1 -> req_template[5]=0x1005; req_threshold correct; req_start high exactly 1 cycle, on the cycle after word 25 is accepted.
- Scanner model drops st_ready for 100 cycles, then raises it with found=1, nonce=0x2A, hash lane i = {32'hA0+i, 32'hB0+i} -> packet: 0x1, 0x2A, 0xB0, 0xA0, ... 0xC8, 0xB8; 52 words; out_last on the last word only.
- st_ready=0 when job load completes -> req_start stays 0 until st_ready rises, then pulses once; a second rise after busy triggers the report.
- Random out_ready backpressure (50%) -> out_data/out_last stable while stalled; no word lost or duplicated.
- rst asserted at word 13 of load, then a full new job -> req_start issued only after the new 26 words; template reflects the new job only.
- With SHA3_SCAN_LOADER_CYCLE_COUNT_EN, 100 busy cycles -> 53 words; word 52 = 100 (±1, per exact busy window: first S_BUSY cycle through capture edge).
